// File: rtl/rr_arbiter5.sv
// -----------------------------------------------------------------------------
// rr_arbiter5
//   Five-port round-robin, packet-locking arbiter driving the one-hot select of
//   the router's 5-input output switch. One requester is granted and locked
//   from head flit to tail flit; priority rotates past the released input.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req[4:0]     per-input request, valid for the flit presented this cycle
//   tail[4:0]    per-input tail-flit marker, qualified by req
//   out_ready    downstream accepts a flit this cycle
//   Gnt[4:0]     registered one-hot grant, 0 = no grant
//   gnt_valid    |Gnt
//   gnt_id[2:0]  binary index of the granted input, 0 when gnt_valid = 0
//   timeout_err  one-cycle pulse on a forced lock release
//
// Build option
//   ARB_LOCK_TIMEOUT_EN  when defined, a lock whose granted input stops
//                        requesting for TIMEOUT_CYCLES cycles is released and
//                        timeout_err pulses; when undefined, a lock persists
//                        until the tail transfers and timeout_err is 0.
// -----------------------------------------------------------------------------
module rr_arbiter5 #(
    parameter int NUM_INPUTS     = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [NUM_INPUTS-1:0] tail,
    input  logic                  out_ready,
    output logic [NUM_INPUTS-1:0] Gnt,
    output logic                  gnt_valid,
    output logic [2:0]            gnt_id,
    output logic                  timeout_err
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                state_q, state_d;
    logic [NUM_INPUTS-1:0] gnt_q, gnt_d;
    logic [2:0]            id_q, id_d;
    logic [2:0]            ptr_q, ptr_d;

    logic                  gnt_active;
    logic                  xfer;
    logic                  tail_xfer;
    logic                  timeout_fire;
    logic [2:0]            ptr_after_id;
    logic [3:0]            cand;
    logic [2:0]            pick_idx;
    logic                  pick_found;

    assign gnt_active   = |(gnt_q & req);
    assign xfer         = gnt_active & out_ready;
    assign tail_xfer    = xfer & (|(gnt_q & tail));
    assign ptr_after_id = (id_q == 3'(NUM_INPUTS - 1)) ? '0 : id_q + 3'd1;

    // Cyclic search starting at ptr: first requester at or after ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            cand = {1'b0, ptr_q} + 4'(i);
            if (cand >= 4'(NUM_INPUTS)) begin
                cand = cand - 4'(NUM_INPUTS);
            end
            if (!pick_found && req[cand[2:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[2:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                id_d  = '0;
                if (pick_found) begin
                    gnt_d[pick_idx] = 1'b1;
                    id_d            = pick_idx;
                    state_d         = LOCKED;
                end
            end
            LOCKED: begin
                // Release leaves one bubble cycle in IDLE before re-arbitration.
                if (tail_xfer || timeout_fire) begin
                    gnt_d   = '0;
                    id_d    = '0;
                    ptr_d   = ptr_after_id;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                id_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_LOCK_TIMEOUT_EN
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       terr_q;

    // Counter value is the number of consecutive idle LOCKED cycles before this one.
    assign timeout_fire = (state_q == LOCKED) && !gnt_active &&
                          (idle_cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        idle_cnt_d = idle_cnt_q + 8'd1;
        if ((state_q != LOCKED) || gnt_active) begin
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
            terr_q     <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            terr_q     <= timeout_fire;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_fire = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    assign Gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = id_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_timeout_range: assert property (@(posedge clk)
        (TIMEOUT_CYCLES >= 2) && (TIMEOUT_CYCLES <= 255));

endmodule
